timer_bank: RTL and testbench
=============================

// Module: timer_bank
// PURPOSE
//  Bank of NCH independent programmable down-counters sharing one clock prescaler.
//  Each channel has a reload register, auto-reload or one-shot mode, start/stop control,
//  a terminal pulse and a sticky flag.
//  Sits beside the CPU bus decode as the system tick/timeout source; oIrq feeds the interrupt controller.
// PARAMETERS
//  WORDSIZE   8  counter/reload width per channel
//  NCH        4  number of channels (1..16); CHW = max(1,clog2(NCH)) derived localparam
//  PRESCALE_W 8  prescaler width
// PORTS
//  iClk       in   1           clock
//  iReset     in   1           asynchronous, active-high reset
//  iLoad      in   1           write iLoadVal into reload+count of channel iLoadCh
//  iLoadCh    in   CHW         load channel select; values >= NCH ignored
//  iLoadVal   in   WORDSIZE    period in ticks (0 => 2^WORDSIZE)
//  iStart     in   NCH         per-channel start strobe
//  iStop      in   NCH         per-channel stop strobe
//  iOneShot   in   NCH         1 = one-shot, 0 = auto-reload (sampled at terminal event)
//  iPrescale  in   PRESCALE_W  tick every iPrescale+1 clocks
//  iFlagClr   in   NCH         clear sticky flags
//  iRdCh      in   CHW         channel shown on oCounter
//  oCounter   out  WORDSIZE    count of channel iRdCh (0 if iRdCh >= NCH); combinational mux
//  oRunning   out  NCH         channel in RUN
//  oReady     out  NCH         registered 1-cycle terminal pulse
//  oFlags     out  NCH         sticky terminal flags
//  oIrq       out  1           |oFlags
// BEHAVIOUR
//  Reset: prescaler, all rCnt, rReload, state=IDLE, oReady, oFlags = 0; so oCounter=0, oIrq=0.
//  Prescaler: pcnt+1 each clock; tick when pcnt >= iPrescale, then pcnt<=0.
//   - iPrescale=0 => tick every clock.
//   - Free-running, not aligned to iStart: first period may be short by up to iPrescale clocks.
//  Channel FSM IDLE/RUN/DONE; priority per channel: iStop > iLoad/iStart > tick.
//   iLoad(c): rReload<=iLoadVal, rCnt<=iLoadVal-1 (mod 2^W); state unchanged; suppresses tick that cycle.
//   iStart in IDLE/DONE: ->RUN, rCnt<=rReload-1; in RUN: restart, same reload.
//    Load+start same cycle: rCnt<=iLoadVal-1, ->RUN.
//   iStop: ->IDLE, rCnt held; no event.
//   RUN & tick & rCnt!=0: rCnt<=rCnt-1.
//   RUN & tick & rCnt==0: terminal event:
//    - oReady[c]=1 next cycle (1 cycle only); oFlags[c]<=1.
//    - auto-reload: rCnt<=rReload-1, stay RUN.
//    - one-shot: ->DONE, rCnt stays 0.
//  Period = N ticks for loaded value N; prescale 0 => oReady every N clocks.
//  Flag set and iFlagClr in same cycle: set wins.
//  DONE behaves as IDLE except remembers completion; iStop in DONE -> IDLE.
//  Reset asserted mid-run: immediate return to reset values; no oReady pulse.
// STRUCTURE
//  Package timer_pkg:
//   - typedef enum logic[1:0] {T_IDLE=0, T_RUN=1, T_DONE=2} timer_state_t
//   - clog2 function
//  Sub-module timer_channel: one per channel via generate.
//   - Holds rReload, rCnt, FSM, oReady, flag.
//   - Inputs: tick, load (decoded), loadval, start, stop, oneshot, flagclr.
//  Top: prescaler, load decode, read mux, irq OR.
// TESTING
//  1. W=8,NCH=4,iPrescale=0: load ch1=5, start1
//     -> oCounter(iRdCh=1) 4,3,2,1,0,4..; oReady[1] pulses every 5 clocks; others 0.
//  2. iPrescale=2, ch2 one-shot, load 3, start
//     -> decrement every 3 clocks; single oReady[2]; then oRunning[2]=0, count 0, oFlags[2]=1, oIrq=1.
//  3. Load 0, auto-reload, prescale 0
//     -> counter 255..0; oReady every 256 clocks.
//  4. Collisions:
//     - stop+start same cycle -> IDLE.
//     - load on terminal cycle -> no oReady, rCnt=new-1.
//     - iFlagClr on terminal -> flag stays 1.
//  5. Reset mid-count on all 4 channels -> all outputs 0 immediately; restart behaves as test 1.
//  6. iLoadCh=5 with NCH=4 -> no state change; iRdCh=7 -> oCounter=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer bank.
// Channel state encoding and channel-index width helpers.
package timer_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_DONE = 2'd2
    } timer_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Channel select width; never narrower than one bit.
    function automatic int chw(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Control/status bundle between the bus decode and the timer bank.
// Strobes are single-cycle; status outputs are level signals with no handshake.
interface timer_bank_if
    import timer_pkg::*;
#(
    parameter int WORDSIZE   = 8,
    parameter int NCH        = 4,
    parameter int PRESCALE_W = 8
);
    localparam int CHW = chw(NCH);

    logic                  load;
    logic [CHW-1:0]        load_ch;
    logic [WORDSIZE-1:0]   load_val;
    logic [NCH-1:0]        start;
    logic [NCH-1:0]        stop;
    logic [NCH-1:0]        one_shot;
    logic [PRESCALE_W-1:0] prescale;
    logic [NCH-1:0]        flag_clr;
    logic [CHW-1:0]        rd_ch;
    logic [WORDSIZE-1:0]   counter;
    logic [NCH-1:0]        running;
    logic [NCH-1:0]        ready;
    logic [NCH-1:0]        flags;
    logic                  irq;

    modport master (
        output load, load_ch, load_val, start, stop, one_shot, prescale, flag_clr, rd_ch,
        input  counter, running, ready, flags, irq
    );

    modport slave (
        input  load, load_ch, load_val, start, stop, one_shot, prescale, flag_clr, rd_ch,
        output counter, running, ready, flags, irq
    );

endinterface

// File: rtl/timer_channel.sv
// One programmable down-counter with reload, one-shot/auto-reload and sticky flag.
// Terminal pulse registered (1 cycle after the terminal tick); no backpressure.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WORDSIZE = 8
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                tick,
    input  logic                load,
    input  logic [WORDSIZE-1:0] load_val,
    input  logic                start,
    input  logic                stop,
    input  logic                one_shot,
    input  logic                flag_clr,
    output logic [WORDSIZE-1:0] cnt,
    output logic                running,
    output logic                ready,
    output logic                flag
);

    localparam logic [WORDSIZE-1:0] ONE = WORDSIZE'(1);

    timer_state_t        state_q, state_d;
    logic [WORDSIZE-1:0] cnt_q, cnt_d;
    logic [WORDSIZE-1:0] reload_q, reload_d;
    logic                ready_q;
    logic                flag_q;
    logic                term;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q  <= T_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            ready_q  <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            ready_q  <= term;
            if (term)
                flag_q <= 1'b1;
            else if (flag_clr)
                flag_q <= 1'b0;
        end
    end

    // Stop beats load/start, which beat the tick; a load swallows that cycle's tick.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        term     = 1'b0;
        if (stop) begin
            state_d = T_IDLE;
        end else if (load || start) begin
            if (load) begin
                reload_d = load_val;
                cnt_d    = load_val - ONE;
            end else begin
                cnt_d    = reload_q - ONE;
            end
            if (start)
                state_d = T_RUN;
        end else if (state_q == T_RUN && tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - ONE;
            end else begin
                term = 1'b1;
                if (one_shot)
                    state_d = T_DONE;
                else
                    cnt_d = reload_q - ONE;
            end
        end
    end

    assign cnt     = cnt_q;
    assign running = (state_q == T_RUN);
    assign ready   = ready_q;
    assign flag    = flag_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH down-counters sharing one free-running prescaler, with read mux and IRQ.
// Counter read is combinational; terminal pulses/flags registered; no backpressure.
module timer_bank
    import timer_pkg::*;
#(
    parameter int WORDSIZE   = 8,
    parameter int NCH        = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic iClk,
    input  logic iReset,
    timer_bank_if.slave bus
);

    localparam int CHW = chw(NCH);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic                  tick;
    logic [WORDSIZE-1:0]   cnt_arr [NCH];
    logic [NCH-1:0]        running_v;
    logic [NCH-1:0]        ready_v;
    logic [NCH-1:0]        flags_v;
    logic [WORDSIZE-1:0]   rd_mux;

    // Prescaler is never realigned by a start, so a first period may run short.
    assign tick = (pcnt_q >= bus.prescale);

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset)
            pcnt_q <= '0;
        else if (tick)
            pcnt_q <= '0;
        else
            pcnt_q <= pcnt_q + PRESCALE_W'(1);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [CHW-1:0] IDX = CHW'(c);

        timer_channel #(
            .WORDSIZE (WORDSIZE)
        ) u_ch (
            .iClk     (iClk),
            .iReset   (iReset),
            .tick     (tick),
            .load     (bus.load && (bus.load_ch == IDX)),
            .load_val (bus.load_val),
            .start    (bus.start[c]),
            .stop     (bus.stop[c]),
            .one_shot (bus.one_shot[c]),
            .flag_clr (bus.flag_clr[c]),
            .cnt      (cnt_arr[c]),
            .running  (running_v[c]),
            .ready    (ready_v[c]),
            .flag     (flags_v[c])
        );
    end

    // Out-of-range channel numbers simply match nothing and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.rd_ch == CHW'(i))
                rd_mux = cnt_arr[i];
        end
    end

    assign bus.counter = rd_mux;
    assign bus.running = running_v;
    assign bus.ready   = ready_v;
    assign bus.flags   = flags_v;
    assign bus.irq     = |flags_v;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: vector table for the basic count/reload flow,
// hand sequences for prescale, zero-load, collisions, reset and out-of-range channels.
module tb_timer_bank;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int PW = 8;

    logic iClk = 1'b0;
    logic iReset;
    always #5 iClk = ~iClk;

    timer_bank_if #(.WORDSIZE(W), .NCH(N), .PRESCALE_W(PW)) bus ();
    timer_bank_if #(.WORDSIZE(W), .NCH(5), .PRESCALE_W(PW)) bus5 ();

    timer_bank #(.WORDSIZE(W), .NCH(N), .PRESCALE_W(PW)) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus.slave)
    );

    timer_bank #(.WORDSIZE(W), .NCH(5), .PRESCALE_W(PW)) dut5 (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus5.slave)
    );

    typedef struct {
        logic       load;
        logic [1:0] lch;
        logic [7:0] lval;
        logic [3:0] start;
        logic [3:0] stop;
        logic [3:0] fclr;
        logic [1:0] rd;
        logic [7:0] e_cnt;
        logic [3:0] e_run;
        logic [3:0] e_rdy;
        logic [3:0] e_flg;
        logic       e_irq;
    } vec_t;

    vec_t tv [15];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load     = 1'b0;
        bus.load_ch  = '0;
        bus.load_val = '0;
        bus.start    = '0;
        bus.stop     = '0;
        bus.flag_clr = '0;
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iReset = 1'b1;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iReset = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 15; i++) begin
            bus.load     = tv[i].load;
            bus.load_ch  = tv[i].lch;
            bus.load_val = tv[i].lval;
            bus.start    = tv[i].start;
            bus.stop     = tv[i].stop;
            bus.flag_clr = tv[i].fclr;
            bus.rd_ch    = tv[i].rd;
            step();
            chk($sformatf("%s v%0d counter", tag, i), bus.counter, tv[i].e_cnt);
            chk($sformatf("%s v%0d running", tag, i), bus.running, tv[i].e_run);
            chk($sformatf("%s v%0d ready", tag, i), bus.ready, tv[i].e_rdy);
            chk($sformatf("%s v%0d flags", tag, i), bus.flags, tv[i].e_flg);
            chk($sformatf("%s v%0d irq", tag, i), bus.irq, tv[i].e_irq);
        end
        idle_inputs();
    endtask

    initial begin
        int n;

        //       load lch lval start   stop    fclr   rd  cnt run     rdy     flg     irq
        tv[0]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0};
        tv[1]  = '{1, 1, 5, 4'b0010, 4'b0000, 4'b0000, 1, 4, 4'b0010, 4'b0000, 4'b0000, 0};
        tv[2]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 3, 4'b0010, 4'b0000, 4'b0000, 0};
        tv[3]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 2, 4'b0010, 4'b0000, 4'b0000, 0};
        tv[4]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0010, 4'b0000, 4'b0000, 0};
        tv[5]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0010, 4'b0000, 4'b0000, 0};
        tv[6]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4, 4'b0010, 4'b0010, 4'b0010, 1};
        tv[7]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 3, 4'b0010, 4'b0000, 4'b0010, 1};
        tv[8]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 2, 4'b0010, 4'b0000, 4'b0010, 1};
        tv[9]  = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0010, 4'b0000, 4'b0010, 1};
        tv[10] = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 4'b0010, 4'b0000, 4'b0010, 1};
        tv[11] = '{0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4, 4'b0010, 4'b0010, 4'b0010, 1};
        tv[12] = '{0, 0, 0, 4'b0000, 4'b0010, 4'b0010, 1, 4, 4'b0000, 4'b0000, 4'b0000, 0};
        tv[13] = '{0, 0, 0, 4'b0010, 4'b0010, 4'b0000, 1, 4, 4'b0000, 4'b0000, 4'b0000, 0};
        tv[14] = '{1, 2, 9, 4'b0000, 4'b0000, 4'b0000, 2, 8, 4'b0000, 4'b0000, 4'b0000, 0};

        iReset        = 1'b1;
        idle_inputs();
        bus.one_shot  = '0;
        bus.prescale  = '0;
        bus.rd_ch     = '0;
        bus5.load     = 1'b0;
        bus5.load_ch  = '0;
        bus5.load_val = '0;
        bus5.start    = '0;
        bus5.stop     = '0;
        bus5.one_shot = '0;
        bus5.prescale = '0;
        bus5.flag_clr = '0;
        bus5.rd_ch    = '0;
        do_reset();

        #1;
        chk("reset counter", bus.counter, 8'd0);
        chk("reset running", bus.running, 4'b0000);
        chk("reset ready", bus.ready, 4'b0000);
        chk("reset irq", bus.irq, 1'b0);

        // Channel numbers past the bank end: load ignored, read returns zero.
        bus5.load     = 1'b1;
        bus5.load_ch  = 3'd5;
        bus5.load_val = 8'd9;
        bus5.rd_ch    = 3'd7;
        step();
        bus5.load = 1'b0;
        chk("oob read ch7", bus5.counter, 8'd0);
        for (int c = 0; c < 6; c++) begin
            bus5.rd_ch = 3'(c);
            #1;
            chk($sformatf("oob load ch5 left ch%0d", c), bus5.counter, 8'd0);
        end
        bus5.load     = 1'b1;
        bus5.load_ch  = 3'd4;
        bus5.load_val = 8'd3;
        bus5.rd_ch    = 3'd4;
        step();
        bus5.load = 1'b0;
        chk("valid load ch4", bus5.counter, 8'd2);

        run_table("basic");

        // Load landing on the terminal cycle replaces the event.
        bus.rd_ch    = 2'd0;
        bus.load     = 1'b1;
        bus.load_ch  = 2'd0;
        bus.load_val = 8'd2;
        bus.start    = 4'b0001;
        step();
        idle_inputs();
        step();
        chk("coll cnt before terminal", bus.counter, 8'd0);
        bus.load     = 1'b1;
        bus.load_ch  = 2'd0;
        bus.load_val = 8'd7;
        step();
        idle_inputs();
        chk("coll load counter", bus.counter, 8'd6);
        chk("coll load no ready", bus.ready[0], 1'b0);
        chk("coll load no flag", bus.flags[0], 1'b0);
        chk("coll load running", bus.running[0], 1'b1);

        // Flag clear coinciding with the terminal event loses to the set.
        repeat (6) step();
        chk("coll clr cnt zero", bus.counter, 8'd0);
        bus.flag_clr = 4'b0001;
        step();
        chk("coll clr ready", bus.ready[0], 1'b1);
        chk("coll clr flag kept", bus.flags[0], 1'b1);
        chk("coll clr reload", bus.counter, 8'd6);
        step();
        chk("clr later flag", bus.flags[0], 1'b0);
        idle_inputs();

        // Load of zero means a full 2^W period.
        bus.rd_ch    = 2'd3;
        bus.load     = 1'b1;
        bus.load_ch  = 2'd3;
        bus.load_val = 8'd0;
        bus.start    = 4'b1000;
        step();
        idle_inputs();
        chk("zero load first count", bus.counter, 8'd255);
        n = 300;
        for (int k = 1; k < 300; k++) begin
            step();
            if (bus.ready[3]) begin
                n = k;
                break;
            end
        end
        chk("zero load period", n, 256);
        chk("zero load reloaded", bus.counter, 8'd255);
        step();
        chk("zero load pulse width", bus.ready[3], 1'b0);

        // Asynchronous reset while every channel is counting.
        bus.start = 4'b0111;
        step();
        idle_inputs();
        repeat (3) step();
        chk("pre-reset running", bus.running, 4'b1111);
        @(negedge iClk);
        iReset = 1'b1;
        #1;
        chk("midrun reset counter", bus.counter, 8'd0);
        chk("midrun reset running", bus.running, 4'b0000);
        chk("midrun reset ready", bus.ready, 4'b0000);
        chk("midrun reset flags", bus.flags, 4'b0000);
        chk("midrun reset irq", bus.irq, 1'b0);
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iReset = 1'b0;
        run_table("restart");

        // One-shot under prescale 2; reset realigns the prescaler phase.
        bus.prescale = 8'd2;
        do_reset();
        bus.one_shot = 4'b0100;
        bus.rd_ch    = 2'd2;
        bus.load     = 1'b1;
        bus.load_ch  = 2'd2;
        bus.load_val = 8'd3;
        bus.start    = 4'b0100;
        step();
        idle_inputs();
        chk("ps e1 counter", bus.counter, 8'd2);
        chk("ps e1 running", bus.running, 4'b0100);
        step();
        chk("ps e2 counter", bus.counter, 8'd2);
        step();
        chk("ps e3 counter", bus.counter, 8'd1);
        repeat (2) step();
        chk("ps e5 counter", bus.counter, 8'd1);
        step();
        chk("ps e6 counter", bus.counter, 8'd0);
        repeat (2) step();
        chk("ps e8 ready", bus.ready, 4'b0000);
        chk("ps e8 running", bus.running, 4'b0100);
        step();
        chk("ps e9 ready", bus.ready, 4'b0100);
        chk("ps e9 running", bus.running, 4'b0000);
        chk("ps e9 counter", bus.counter, 8'd0);
        chk("ps e9 flags", bus.flags, 4'b0100);
        chk("ps e9 irq", bus.irq, 1'b1);
        step();
        chk("ps e10 ready", bus.ready, 4'b0000);
        repeat (10) step();
        chk("ps one-shot quiet", bus.ready, 4'b0000);
        chk("ps flag sticky", bus.flags, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
